// File: rtl/ibuf_shift_ctl_pkg.sv
// ibuf_shift_ctl_pkg: shared IFU state encoding and instruction-buffer defaults.
package ibuf_shift_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        RUN   = 2'b10,
        FLUSH = 2'b11
    } state_e;

    localparam int IBUF_DEPTH_DEF = 16;
    localparam int FILL_BYTES_DEF = 4;
    localparam int RUN_THRESH_DEF = 7;

endpackage

// File: rtl/ibuf_shift_dec.sv
// ibuf_shift_dec: one-hot shift to binary byte count; zero or multi-hot flags err and yields 0.
module ibuf_shift_dec (
    input  logic [7:0] shift_oh,
    output logic [3:0] k,
    output logic       err
);

    always_comb begin
        k = '0;
        for (int i = 0; i < 8; i++) k = shift_oh[i] ? 4'(i) : k;
        err = (shift_oh == 8'd0) || ((shift_oh & (shift_oh - 8'd1)) != 8'd0);
        k = err ? 4'd0 : k;
    end

endmodule

// File: rtl/ibuf_shift_ctl.sv
// ibuf_shift_ctl: instruction-buffer occupancy, pointers, fill/shift/flush sequencing.
// Define IBUF_SHIFT_STATS_EN to add the saturating stall_cnt output.
module ibuf_shift_ctl
    import ibuf_shift_ctl_pkg::*;
#(
    parameter int IBUF_DEPTH = IBUF_DEPTH_DEF,
    parameter int FILL_BYTES = FILL_BYTES_DEF,
    parameter int RUN_THRESH = RUN_THRESH_DEF
) (
    input  logic                          clk,
    input  logic                          reset_l,
    input  logic                          icu_fill_vld,
    output logic                          ibuf_fill_rdy,
    input  logic [7:0]                    iu_shift_d,
    input  logic [3:0]                    len_first_inst,
    input  logic                          iu_flush,
    output logic                          not_valid,
    output logic [$clog2(IBUF_DEPTH):0]   ibuf_cnt,
    output logic [$clog2(IBUF_DEPTH)-1:0] ibuf_rd_ptr,
    output logic [$clog2(IBUF_DEPTH)-1:0] ibuf_wr_ptr,
    output logic                          shift_err
`ifdef IBUF_SHIFT_STATS_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;

    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d, k_ext, k_eff;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          err_q, err_d;
    logic [3:0]    dec_k;
    logic          dec_err, run, over, accept;

    ibuf_shift_dec u_dec (
        .shift_oh (iu_shift_d),
        .k        (dec_k),
        .err      (dec_err)
    );

    assign run           = (state_q == RUN);
    assign ibuf_fill_rdy = (state_q == FILL || run) && (cnt_q <= CW'(IBUF_DEPTH - FILL_BYTES));
    assign not_valid     = !run || (cnt_q < CW'(len_first_inst));
    // Flush wins over a beat the ICU sees as accepted from the registered ready.
    assign accept        = icu_fill_vld && ibuf_fill_rdy && !iu_flush;

    always_comb begin
        k_ext = CW'(dec_k);
        over  = k_ext > cnt_q;
        k_eff = !run ? '0 : over ? cnt_q : k_ext;
        cnt_d = iu_flush ? '0 : cnt_q - k_eff + (accept ? CW'(FILL_BYTES) : '0);
        rd_d  = iu_flush ? '0 : rd_q + PW'(k_eff);
        wr_d  = iu_flush ? '0 : accept ? wr_q + PW'(FILL_BYTES) : wr_q;
        err_d = !iu_flush && run && (dec_err || over);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            err_q <= err_d;
            if (iu_flush) state_q <= FLUSH;
            else begin
                case (state_q)
                    IDLE:  state_q <= FILL;
                    FILL:  state_q <= (cnt_q >= CW'(RUN_THRESH)) ? RUN : FILL;
                    RUN:   state_q <= (cnt_q == '0) ? FILL : RUN;
                    FLUSH: state_q <= FILL;
                endcase
            end
        end
    end

    assign ibuf_cnt    = cnt_q;
    assign ibuf_rd_ptr = rd_q;
    assign ibuf_wr_ptr = wr_q;
    assign shift_err   = err_q;

`ifdef IBUF_SHIFT_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) stall_q <= '0;
        else if (run && not_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ibuf_shift_ctl.sv
// tb_ibuf_shift_ctl: directed vector table, async-reset check, and randomized run against a byte-count model.
module tb_ibuf_shift_ctl;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       icu_fill_vld = 1'b0;
    logic       ibuf_fill_rdy;
    logic [7:0] iu_shift_d = 8'h01;
    logic [3:0] len_first_inst = 4'd3;
    logic       iu_flush = 1'b0;
    logic       not_valid;
    logic [4:0] ibuf_cnt;
    logic [3:0] ibuf_rd_ptr, ibuf_wr_ptr;
    logic       shift_err;
`ifdef IBUF_SHIFT_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibuf_shift_ctl dut (
        .clk            (clk),
        .reset_l        (reset_l),
        .icu_fill_vld   (icu_fill_vld),
        .ibuf_fill_rdy  (ibuf_fill_rdy),
        .iu_shift_d     (iu_shift_d),
        .len_first_inst (len_first_inst),
        .iu_flush       (iu_flush),
        .not_valid      (not_valid),
        .ibuf_cnt       (ibuf_cnt),
        .ibuf_rd_ptr    (ibuf_rd_ptr),
        .ibuf_wr_ptr    (ibuf_wr_ptr),
        .shift_err      (shift_err)
`ifdef IBUF_SHIFT_STATS_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         vld;
        logic [7:0] sh;
        bit         fl;
        int         cnt, rd, wr;
        bit         rdy, nv, err;
    } vec_t;

    vec_t tv[24];

    // Model: state 0 idle, 1 fill, 2 run, 3 flush
    int mst, mcnt, mrd, mwr, merr, mstall;

    function automatic bit m_rdy();
        return (mst == 1 || mst == 2) && mcnt <= 12;
    endfunction

    function automatic bit m_nv(int len);
        return mst != 2 || mcnt < len;
    endfunction

    task automatic m_reset();
        mst = 0; mcnt = 0; mrd = 0; mwr = 0; merr = 0; mstall = 0;
    endtask

    task automatic m_step(input bit vld, input logic [7:0] sh, input bit fl, input int len);
        int k, nst;
        bit e, acc;
        if (mst == 2 && m_nv(len) && mstall < 65535) mstall++;
        if (fl) begin
            mst = 3; mcnt = 0; mrd = 0; mwr = 0; merr = 0;
            return;
        end
        acc = vld && m_rdy();
        k = 0;
        e = 0;
        if (mst == 2) begin
            if ($countones(sh) != 1) e = 1;
            else begin
                for (int i = 0; i < 8; i++) if (sh[i]) k = i;
                if (k > mcnt) begin k = mcnt; e = 1; end
            end
        end
        case (mst)
            0: nst = 1;
            1: nst = (mcnt >= 7) ? 2 : 1;
            2: nst = (mcnt == 0) ? 1 : 2;
            default: nst = 1;
        endcase
        mcnt = mcnt - k + (acc ? 4 : 0);
        mrd  = (mrd + k) % 16;
        mwr  = acc ? (mwr + 4) % 16 : mwr;
        merr = e;
        mst  = nst;
    endtask

    initial begin
        tv[0]  = '{1, 8'h01, 0,  0,  0,  0, 1, 1, 0};
        tv[1]  = '{1, 8'h01, 0,  4,  0,  4, 1, 1, 0};
        tv[2]  = '{1, 8'h01, 0,  8,  0,  8, 1, 1, 0};
        tv[3]  = '{0, 8'h08, 0,  8,  0,  8, 1, 0, 0};
        tv[4]  = '{1, 8'h08, 0,  9,  3, 12, 1, 0, 0};
        tv[5]  = '{1, 8'h01, 0, 13,  3,  0, 0, 0, 0};
        tv[6]  = '{1, 8'h02, 0, 12,  4,  0, 1, 0, 0};
        tv[7]  = '{0, 8'h06, 0, 12,  4,  0, 1, 0, 1};
        tv[8]  = '{0, 8'h01, 0, 12,  4,  0, 1, 0, 0};
        tv[9]  = '{0, 8'h80, 0,  5, 11,  0, 1, 0, 0};
        tv[10] = '{1, 8'h08, 0,  6, 14,  4, 1, 0, 0};
        tv[11] = '{1, 8'h20, 0,  5,  3,  8, 1, 0, 0};
        tv[12] = '{0, 8'h08, 0,  2,  6,  8, 1, 1, 0};
        tv[13] = '{0, 8'h40, 0,  0,  8,  8, 1, 1, 1};
        tv[14] = '{0, 8'h01, 0,  0,  8,  8, 1, 1, 0};
        tv[15] = '{1, 8'h01, 0,  4,  8, 12, 1, 1, 0};
        tv[16] = '{1, 8'h01, 0,  8,  8,  0, 1, 1, 0};
        tv[17] = '{0, 8'h01, 0,  8,  8,  0, 1, 0, 0};
        tv[18] = '{1, 8'h08, 1,  0,  0,  0, 0, 1, 0};
        tv[19] = '{1, 8'h01, 0,  0,  0,  0, 1, 1, 0};
        tv[20] = '{1, 8'h01, 0,  4,  0,  4, 1, 1, 0};
        tv[21] = '{1, 8'h01, 1,  0,  0,  0, 0, 1, 0};
        tv[22] = '{1, 8'h01, 1,  0,  0,  0, 0, 1, 0};
        tv[23] = '{0, 8'h01, 0,  0,  0,  0, 1, 1, 0};

        #12;
        chk("rst_cnt", ibuf_cnt, 0);
        chk("rst_rd", ibuf_rd_ptr, 0);
        chk("rst_wr", ibuf_wr_ptr, 0);
        chk("rst_rdy", ibuf_fill_rdy, 0);
        chk("rst_nv", not_valid, 1);
        chk("rst_err", shift_err, 0);

        @(negedge clk);
        reset_l = 1'b1;
        for (int i = 0; i < 24; i++) begin
            icu_fill_vld = tv[i].vld;
            iu_shift_d   = tv[i].sh;
            iu_flush     = tv[i].fl;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_cnt", i), ibuf_cnt, tv[i].cnt);
            chk($sformatf("v%0d_rd", i), ibuf_rd_ptr, tv[i].rd);
            chk($sformatf("v%0d_wr", i), ibuf_wr_ptr, tv[i].wr);
            chk($sformatf("v%0d_rdy", i), ibuf_fill_rdy, tv[i].rdy);
            chk($sformatf("v%0d_nv", i), not_valid, tv[i].nv);
            chk($sformatf("v%0d_err", i), shift_err, tv[i].err);
        end
`ifdef IBUF_SHIFT_STATS_EN
        chk("tbl_stall", stall_cnt, 2);
`endif

        icu_fill_vld = 1'b0;
        iu_flush = 1'b0;
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            icu_fill_vld   = ($urandom_range(99) < 75);
            iu_flush       = ($urandom_range(99) < 2);
            len_first_inst = 4'($urandom_range(8, 1));
            iu_shift_d     = ($urandom_range(99) < 85) ? (8'h01 << $urandom_range(7)) : 8'($urandom);
            #1;
            chk("rnd_cnt", ibuf_cnt, mcnt);
            chk("rnd_rd", ibuf_rd_ptr, mrd);
            chk("rnd_wr", ibuf_wr_ptr, mwr);
            chk("rnd_rdy", ibuf_fill_rdy, m_rdy());
            chk("rnd_nv", not_valid, m_nv(len_first_inst));
            chk("rnd_err", shift_err, merr);
`ifdef IBUF_SHIFT_STATS_EN
            chk("rnd_stall", stall_cnt, mstall);
`endif
            m_step(icu_fill_vld, iu_shift_d, iu_flush, len_first_inst);
            @(negedge clk);
        end

        icu_fill_vld = 1'b1;
        iu_flush = 1'b0;
        iu_shift_d = 8'h01;
        repeat (3) @(negedge clk);
        chk("pre_arst_cnt_nz", (ibuf_cnt != 0 || ibuf_wr_ptr != 0), 1);
        #2;
        reset_l = 1'b0;
        #1;
        chk("arst_cnt", ibuf_cnt, 0);
        chk("arst_rd", ibuf_rd_ptr, 0);
        chk("arst_wr", ibuf_wr_ptr, 0);
        chk("arst_rdy", ibuf_fill_rdy, 0);
        chk("arst_nv", not_valid, 1);
        chk("arst_err", shift_err, 0);
`ifdef IBUF_SHIFT_STATS_EN
        chk("arst_stall", stall_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibuf_shift_ctl.md
# ibuf_shift_ctl

Instruction-buffer occupancy and shift controller for the IFU decode stage. It tracks how many valid bytes the circular instruction buffer holds, accepts 4-byte fill beats from the ICU, and retires the one-hot `iu_shift_d` byte count from the length decoder. It generates `not_valid` back to the length decoder and owns the buffer read and write pointers. It also sequences start-up fill and branch/trap flushes.

## Interface

Parameters:
- `IBUF_DEPTH`, 16: buffer size in bytes; power of two.
- `FILL_BYTES`, 4: bytes delivered per accepted fill beat.
- `RUN_THRESH`, 7: minimum valid bytes before leaving FILL.

Ports:
- `clk`  in  1  single core clock.
- `reset_l`  in  1  asynchronous, active-low reset.
- `icu_fill_vld`  in  1  ICU presents a fill beat.
- `ibuf_fill_rdy`  out  1  controller accepts a beat this cycle. A beat is accepted when `icu_fill_vld` and `ibuf_fill_rdy` are both high.
- `iu_shift_d`  in  8  one-hot shift amount; bit k set means consume k bytes.
- `len_first_inst`  in  4  binary length (1..8) of the instruction at the read pointer.
- `iu_flush`  in  1  redirect; discard all buffered bytes.
- `not_valid`  out  1  buffer cannot supply the first instruction.
- `ibuf_cnt`  out  5  valid byte count, 0..`IBUF_DEPTH`.
- `ibuf_rd_ptr`  out  4  byte read pointer.
- `ibuf_wr_ptr`  out  4  byte write pointer.
- `shift_err`  out  1  one-cycle pulse on an illegal shift.
- `stall_cnt`  out  16  present only with `IBUF_SHIFT_STATS_EN`.

## Operation

- **States.** IDLE, FILL, RUN, FLUSH.
  - IDLE → FILL on the first cycle after reset.
  - FILL → RUN when the registered `ibuf_cnt` ≥ `RUN_THRESH`.
  - RUN → FILL when `ibuf_cnt` = 0.
  - Any state → FLUSH on `iu_flush`.
  - FLUSH → FILL after exactly one cycle.
- **Fill ready.** `ibuf_fill_rdy` = (state is FILL or RUN) and `ibuf_cnt` ≤ `IBUF_DEPTH` − `FILL_BYTES`. It is computed from registered state only; the same-cycle shift is not credited.
- **Shift decode.** The shift is applied only in RUN, with k = index of the set bit.
  - `iu_shift_d` = 0 or multi-hot: treat as k = 0 and pulse `shift_err`.
  - k > `ibuf_cnt`: clamp k to `ibuf_cnt` and pulse `shift_err`.
  - Shifts presented outside RUN are ignored silently.
- **Count update.** `ibuf_cnt` ← `ibuf_cnt` − k + (accept ? `FILL_BYTES` : 0). Overflow cannot occur by construction of `ibuf_fill_rdy`.
- **Pointer update.**
  - `ibuf_rd_ptr` ← (`ibuf_rd_ptr` + k) mod `IBUF_DEPTH`.
  - `ibuf_wr_ptr` ← (`ibuf_wr_ptr` + `FILL_BYTES`) mod `IBUF_DEPTH` on accept.
  - Both pointers wrap silently.
- **not_valid.** `not_valid` = (state ≠ RUN) or (`ibuf_cnt` < `len_first_inst`). It is combinational from registered state.
- **Flush.**
  - `iu_flush` has priority over shift and fill in the same cycle.
  - The next edge clears `ibuf_cnt`, `ibuf_rd_ptr` and `ibuf_wr_ptr` to 0.
  - During the FLUSH cycle `ibuf_fill_rdy` = 0, so a stale beat is not accepted.
  - `iu_flush` held for several cycles keeps the controller in FLUSH.
- **Simultaneous fill and shift** in RUN both apply in the same edge.

## Timing

- **Reset values** (asserted whenever `reset_l` = 0, independent of `clk`):
  - state = IDLE.
  - `ibuf_cnt`, `ibuf_rd_ptr`, `ibuf_wr_ptr`, `shift_err`, `stall_cnt` = 0.
  - `ibuf_fill_rdy` = 0.
  - `not_valid` = 1.
- **Latency.**
  - An accepted beat is visible in `ibuf_cnt` one cycle later.
  - A shift is reflected in `ibuf_rd_ptr` and `ibuf_cnt` one cycle later.
  - `shift_err` is registered and pulses one cycle after the offending shift.
- **Startup.** The earliest RUN entry is 2 accepted beats after the IDLE→FILL transition (8 ≥ 7).
- **Reset mid-operation.** All state is dropped immediately. An in-flight ICU beat is lost, and the ICU must re-request after reset.

## Configuration

- **`IBUF_SHIFT_STATS_EN` defined:**
  - `stall_cnt` increments each cycle where state = RUN and `not_valid` = 1.
  - The count saturates at 16'hFFFF.
  - `iu_flush` does not clear it; only reset does.
- **`IBUF_SHIFT_STATS_EN` undefined:** the `stall_cnt` port and its counter are absent.

## Structure

- **Shared IFU package:**
  - State encoding constants: IDLE = 2'b00, FILL = 2'b01, RUN = 2'b10, FLUSH = 2'b11.
  - Default values of `IBUF_DEPTH`, `FILL_BYTES` and `RUN_THRESH`.
- **Sub-module `ibuf_shift_dec`:** combinational one-hot-to-binary shift decoder with illegal-pattern detection. It returns k and an error bit, and is reusable by the fold logic.
- **Everything else lives in one module:** FSM, counter, pointers and stats counter.

## Test plan

- **Reset and startup.** Release `reset_l`, hold `icu_fill_vld` = 1 → `ibuf_fill_rdy` rises in FILL; `ibuf_cnt` reads 4 then 8; RUN entered; `not_valid` = 0 with `len_first_inst` = 3.
- **Fill/shift mix.** With `ibuf_cnt` = 8 in RUN, shift 3 (8'b0000_1000) plus an accepted beat → `ibuf_cnt` = 9, `ibuf_rd_ptr` += 3.
- **Full.** With `ibuf_cnt` = 13 → `ibuf_fill_rdy` = 0. After shift 1, `ibuf_cnt` = 12 → `ibuf_fill_rdy` = 1 the next cycle.
- **Wrap-around.** With `ibuf_rd_ptr` = 14, shift 5 → `ibuf_rd_ptr` = 3. With `ibuf_wr_ptr` = 12, one accepted beat → `ibuf_wr_ptr` = 0.
- **Illegal shift.** With `ibuf_cnt` = 2, shift 6 → `ibuf_cnt` = 0 and a 1-cycle `shift_err` pulse. Multi-hot 8'b0000_0110 → no consumption and a `shift_err` pulse.
- **Flush.** `iu_flush` asserted together with a shift and a fill beat → next cycle `ibuf_cnt`, `ibuf_rd_ptr`, `ibuf_wr_ptr` = 0, state FLUSH, `ibuf_fill_rdy` = 0, then FILL. With `IBUF_SHIFT_STATS_EN`, `stall_cnt` keeps its value.
